// File: rtl/fir_par_pkg.sv
// -----------------------------------------------------------------------------
// fir_par_pkg
// Shared definitions for the L=3 parallel FIR datapath: the input deserializer,
// the fast-FIR core and the output serializer all import this package.
//   L_PAR          samples per parallel block (lane 0 = earliest sample)
//   DATA_OUT_WIDTH width of one filter output sample
//   BLK_DEPTH      default number of blocks buffered in the output serializer
//   sample_t       one signed filter output sample
//   block_t        one block of L_PAR samples, lane i at bits [i*W +: W]
//   clog2_min1     $clog2 clamped to at least 1 so counters never get zero width
// -----------------------------------------------------------------------------
package fir_par_pkg;

   localparam int L_PAR          = 3;
   localparam int DATA_OUT_WIDTH = 64;
   localparam int BLK_DEPTH      = 2;

   typedef logic signed [DATA_OUT_WIDTH-1:0] sample_t;
   typedef sample_t [L_PAR-1:0]              block_t;

   function automatic int clog2_min1(input int n);
      return ($clog2(n) < 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/fir_blk_fifo.sv
// -----------------------------------------------------------------------------
// fir_blk_fifo
// DEPTH-entry circular buffer of whole blocks. The head entry stays readable on
// o_rd_data until popped; o_count_next exposes the post-edge occupancy so the
// owner can register its ready flag without a combinational path from the sink.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   i_flush        synchronous clear of pointers and count (wins over push/pop)
//   i_push         write i_wr_data at the tail (ignored when full)
//   i_wr_data      block to store, WIDTH bits
//   i_pop          retire the head entry (ignored when empty)
//   o_rd_data      head entry
//   o_count        entries currently held (registered)
//   o_count_next   occupancy after the coming edge
// -----------------------------------------------------------------------------
module fir_blk_fifo
   import fir_par_pkg::*;
#(
   parameter  int WIDTH = L_PAR * DATA_OUT_WIDTH,
   parameter  int DEPTH = BLK_DEPTH,
   localparam int CNT_W = $clog2(DEPTH + 1)
)
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_flush,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rd_data,
   output logic [CNT_W-1:0] o_count,
   output logic [CNT_W-1:0] o_count_next
);

   localparam int PTR_W = clog2_min1(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] w_count_next;
   logic             w_full;
   logic             w_empty;
   logic             w_do_push;
   logic             w_do_pop;

   // Pointers wrap explicitly at DEPTH, which need not be a power of two.
   function automatic logic [PTR_W-1:0] f_ptr_inc(input logic [PTR_W-1:0] ptr);
      if (ptr == PTR_W'(DEPTH - 1)) begin
         return {PTR_W{1'b0}};
      end else begin
         return ptr + PTR_W'(1);
      end
   endfunction

   assign w_full    = (r_count == CNT_W'(DEPTH));
   assign w_empty   = (r_count == {CNT_W{1'b0}});
   assign w_do_push = i_push && !w_full && !i_flush;
   assign w_do_pop  = i_pop && !w_empty && !i_flush;

   // Occupancy after this edge; a simultaneous push and pop leaves it unchanged.
   always_comb begin
      w_count_next = r_count;
      if (i_flush) begin
         w_count_next = {CNT_W{1'b0}};
      end else begin
         case ({w_do_push, w_do_pop})
            2'b10:   w_count_next = r_count + CNT_W'(1);
            2'b01:   w_count_next = r_count - CNT_W'(1);
            default: w_count_next = r_count;
         endcase
      end
   end

   // Pointer and count registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= {PTR_W{1'b0}};
         r_rd_ptr <= {PTR_W{1'b0}};
         r_count  <= {CNT_W{1'b0}};
      end else if (i_flush) begin
         r_wr_ptr <= {PTR_W{1'b0}};
         r_rd_ptr <= {PTR_W{1'b0}};
         r_count  <= {CNT_W{1'b0}};
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= f_ptr_inc(r_wr_ptr);
         end
         if (w_do_pop) begin
            r_rd_ptr <= f_ptr_inc(r_rd_ptr);
         end
         r_count <= w_count_next;
      end
   end

   // Block storage; cleared on reset so no stale data is ever observable.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= {WIDTH{1'b0}};
         end
      end else if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_wr_data;
      end
   end

   assign o_rd_data    = r_mem[r_rd_ptr];
   assign o_count      = r_count;
   assign o_count_next = w_count_next;

endmodule

// File: rtl/fir_l3_out_serializer.sv
// -----------------------------------------------------------------------------
// fir_l3_out_serializer
// Output end of the 3-parallel fast-FIR: takes one block of L samples per
// handshake and re-emits them one per clock, lane 0 first, with valid/ready
// backpressure on both sides. Samples pass through bit-exact.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   flush_i        synchronous clear of all buffered data and the output slot
//   blk_valid_i    input block valid
//   blk_ready_o    input block ready (registered)
//   blk_data_i     L lanes, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   out_valid_o    serial sample valid (registered)
//   out_ready_i    serial sink ready
//   out_data_o     serial sample (registered)
//   out_last_o     marks lane L-1 of a block (registered)
//   occupancy_o    blocks held in the FIFO, including a partially emitted head
// -----------------------------------------------------------------------------
module fir_l3_out_serializer
   import fir_par_pkg::*;
#(
   parameter  int DATA_WIDTH = DATA_OUT_WIDTH,
   parameter  int L          = L_PAR,
   parameter  int DEPTH      = BLK_DEPTH,
   localparam int CNT_W      = $clog2(DEPTH + 1)
)
(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  flush_i,
   input  logic                  blk_valid_i,
   output logic                  blk_ready_o,
   input  logic [L*DATA_WIDTH-1:0] blk_data_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [DATA_WIDTH-1:0] out_data_o,
   output logic                  out_last_o,
   output logic [CNT_W-1:0]      occupancy_o
);

   localparam int                LANE_W    = clog2_min1(L);
   localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(L - 1);

   // EMPTY: no block held, lane index parked at 0. EMIT: head block draining.
   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_EMIT  = 1'b1
   } lane_state_t;

   lane_state_t           r_state;
   lane_state_t           w_state_next;
   logic [LANE_W-1:0]     r_lane_idx;
   logic [LANE_W-1:0]     w_lane_idx_next;
   logic                  r_out_valid;
   logic                  w_out_valid_next;
   logic                  r_out_last;
   logic                  w_out_last_next;
   logic [DATA_WIDTH-1:0] r_out_data;
   logic [DATA_WIDTH-1:0] w_out_data_next;
   logic                  r_blk_ready;
   logic                  w_blk_ready_next;

   logic                    w_out_free;
   logic                    w_push;
   logic                    w_pop;
   logic [L*DATA_WIDTH-1:0] w_head;
   logic [DATA_WIDTH-1:0]   w_lanes [L];
   logic [CNT_W-1:0]        w_count;
   logic [CNT_W-1:0]        w_count_next;

   // Flush drops any block offered in the same cycle.
   assign w_push     = blk_valid_i && r_blk_ready && !flush_i;
   assign w_out_free = !r_out_valid || out_ready_i;

   fir_blk_fifo #(
      .WIDTH (L * DATA_WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk          (clk),
      .reset_n      (reset_n),
      .i_flush      (flush_i),
      .i_push       (w_push),
      .i_wr_data    (blk_data_i),
      .i_pop        (w_pop),
      .o_rd_data    (w_head),
      .o_count      (w_count),
      .o_count_next (w_count_next)
   );

   for (genvar g = 0; g < L; g++) begin : g_lane
      assign w_lanes[g] = w_head[g*DATA_WIDTH +: DATA_WIDTH];
   end

   // Lane FSM and output-slot next state; the head block pops with its last lane.
   always_comb begin
      w_lane_idx_next  = r_lane_idx;
      w_out_valid_next = r_out_valid;
      w_out_last_next  = r_out_last;
      w_out_data_next  = r_out_data;
      w_pop            = 1'b0;
      if (flush_i) begin
         w_lane_idx_next  = {LANE_W{1'b0}};
         w_out_valid_next = 1'b0;
         w_out_last_next  = 1'b0;
      end else begin
         case (r_state)
            ST_EMIT: begin
               if (w_out_free) begin
                  w_out_data_next  = w_lanes[r_lane_idx];
                  w_out_last_next  = (r_lane_idx == LANE_LAST);
                  w_out_valid_next = 1'b1;
                  if (r_lane_idx == LANE_LAST) begin
                     w_lane_idx_next = {LANE_W{1'b0}};
                     w_pop           = 1'b1;
                  end else begin
                     w_lane_idx_next = r_lane_idx + LANE_W'(1);
                  end
               end else begin
                  w_lane_idx_next = r_lane_idx;
               end
            end
            ST_EMPTY: begin
               w_lane_idx_next = {LANE_W{1'b0}};
               if (w_out_free) begin
                  w_out_valid_next = 1'b0;
                  w_out_last_next  = 1'b0;
               end else begin
                  w_out_valid_next = r_out_valid;
               end
            end
            default: begin
               w_lane_idx_next  = {LANE_W{1'b0}};
               w_out_valid_next = 1'b0;
               w_out_last_next  = 1'b0;
            end
         endcase
      end
   end

   // Ready and FSM state follow the post-edge FIFO occupancy, never out_ready_i directly.
   always_comb begin
      w_state_next     = r_state;
      w_blk_ready_next = r_blk_ready;
      if (flush_i) begin
         w_state_next     = ST_EMPTY;
         w_blk_ready_next = 1'b1;
      end else begin
         w_state_next     = (w_count_next != {CNT_W{1'b0}}) ? ST_EMIT : ST_EMPTY;
         w_blk_ready_next = (w_count_next < CNT_W'(DEPTH));
      end
   end

   // State, lane index, output slot and ready registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_EMPTY;
         r_lane_idx  <= {LANE_W{1'b0}};
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_out_data  <= {DATA_WIDTH{1'b0}};
         r_blk_ready <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_lane_idx  <= w_lane_idx_next;
         r_out_valid <= w_out_valid_next;
         r_out_last  <= w_out_last_next;
         r_out_data  <= w_out_data_next;
         r_blk_ready <= w_blk_ready_next;
      end
   end

   assign blk_ready_o = r_blk_ready;
   assign out_valid_o = r_out_valid;
   assign out_last_o  = r_out_last;
   assign out_data_o  = r_out_data;
   assign occupancy_o = w_count;

endmodule

// File: tb/tb_fir_l3_out_serializer.sv
module tb_fir_l3_out_serializer;
   import fir_par_pkg::*;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         flush_i;
   logic         blk_valid_i;
   logic         blk_ready_o;
   block_t       blk_data;
   logic         out_valid_o;
   logic         out_ready_i;
   logic [63:0]  out_data_o;
   logic         out_last_o;
   logic [1:0]   occupancy_o;

   int n_err = 0;
   int n_chk = 0;

   logic [63:0] exp4 [8];
   logic [63:0] s5   [30];

   always #5 clk = ~clk;

   fir_l3_out_serializer dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .flush_i     (flush_i),
      .blk_valid_i (blk_valid_i),
      .blk_ready_o (blk_ready_o),
      .blk_data_i  (blk_data),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_data_o  (out_data_o),
      .out_last_o  (out_last_o),
      .occupancy_o (occupancy_o)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_blk(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
      blk_data[0] = a;
      blk_data[1] = b;
      blk_data[2] = c;
   endtask

   initial begin
      reset_n     = 1'b0;
      flush_i     = 1'b0;
      blk_valid_i = 1'b0;
      out_ready_i = 1'b0;
      set_blk(64'h0, 64'h0, 64'h0);

      // 1: reset
      repeat (5) tick();
      chk("rst_valid", out_valid_o, 1'b0);
      chk("rst_ready", blk_ready_o, 1'b0);
      chk("rst_occ",   occupancy_o, 2'd0);
      chk("rst_data",  out_data_o,  64'h0);
      chk("rst_last",  out_last_o,  1'b0);
      reset_n = 1'b1;
      #1;
      chk("rel_ready_before_edge", blk_ready_o, 1'b0);
      tick();
      chk("rel_ready_after_edge", blk_ready_o, 1'b1);
      chk("rel_valid", out_valid_o, 1'b0);

      // 2: single block, sink always ready
      out_ready_i = 1'b1;
      set_blk(64'h11, 64'h22, 64'h33);
      blk_valid_i = 1'b1;
      tick();
      blk_valid_i = 1'b0;
      chk("t2_accept_valid", out_valid_o, 1'b0);
      chk("t2_accept_occ",   occupancy_o, 2'd1);
      tick();
      chk("t2_s0_valid", out_valid_o, 1'b1);
      chk("t2_s0_data",  out_data_o,  64'h11);
      chk("t2_s0_last",  out_last_o,  1'b0);
      tick();
      chk("t2_s1_data",  out_data_o,  64'h22);
      chk("t2_s1_last",  out_last_o,  1'b0);
      tick();
      chk("t2_s2_data",  out_data_o,  64'h33);
      chk("t2_s2_last",  out_last_o,  1'b1);
      chk("t2_s2_occ",   occupancy_o, 2'd0);
      tick();
      chk("t2_idle_valid", out_valid_o, 1'b0);

      // 3: backpressure while lane 1 is shown
      blk_valid_i = 1'b1;
      tick();
      blk_valid_i = 1'b0;
      tick();
      chk("t3_s0_data", out_data_o, 64'h11);
      tick();
      chk("t3_s1_data", out_data_o, 64'h22);
      out_ready_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t3_hold_data",  out_data_o,  64'h22);
         chk("t3_hold_valid", out_valid_o, 1'b1);
         chk("t3_hold_occ",   occupancy_o, 2'd1);
      end
      out_ready_i = 1'b1;
      tick();
      chk("t3_s2_data", out_data_o, 64'h33);
      chk("t3_s2_last", out_last_o, 1'b1);
      tick();
      chk("t3_idle_valid", out_valid_o, 1'b0);

      // 4: fill the FIFO with the sink stalled
      out_ready_i = 1'b0;
      set_blk(64'hA0, 64'hA1, 64'hA2);
      blk_valid_i = 1'b1;
      tick();
      set_blk(64'hB0, 64'hB1, 64'hB2);
      tick();
      chk("t4_full_occ",   occupancy_o, 2'd2);
      chk("t4_full_ready", blk_ready_o, 1'b0);
      chk("t4_a0_data",    out_data_o,  64'hA0);
      set_blk(64'hC0, 64'hC1, 64'hC2);
      tick();
      chk("t4_stall_occ",   occupancy_o, 2'd2);
      chk("t4_stall_ready", blk_ready_o, 1'b0);
      chk("t4_stall_data",  out_data_o,  64'hA0);
      exp4[0] = 64'hA1; exp4[1] = 64'hA2; exp4[2] = 64'hB0; exp4[3] = 64'hB1;
      exp4[4] = 64'hB2; exp4[5] = 64'hC0; exp4[6] = 64'hC1; exp4[7] = 64'hC2;
      out_ready_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("t4_seq_data",  out_data_o,  exp4[i]);
         chk("t4_seq_valid", out_valid_o, 1'b1);
         if (i == 1) begin
            chk("t4_a2_last",   out_last_o,  1'b1);
            chk("t4_a2_ready",  blk_ready_o, 1'b1);
            chk("t4_a2_occ",    occupancy_o, 2'd1);
         end
         if (i == 2) begin
            blk_valid_i = 1'b0;
            chk("t4_c_acc_occ",   occupancy_o, 2'd2);
            chk("t4_c_acc_ready", blk_ready_o, 1'b0);
         end
      end
      chk("t4_end_occ", occupancy_o, 2'd0);
      tick();
      chk("t4_idle_valid", out_valid_o, 1'b0);

      // 5: streaming, one block every 3 clocks
      for (int j = 0; j < 30; j++) s5[j] = 64'h0123_4567_89AB_0000 + 64'(j);
      s5[4]  = 64'hFFFF_FFFF_FFFF_FFFF;
      s5[17] = 64'h8000_0000_0000_0000;
      s5[29] = 64'h0;
      for (int k = 0; k < 32; k++) begin
         if ((k % 3) == 0 && k < 30) begin
            set_blk(s5[k], s5[k+1], s5[k+2]);
            blk_valid_i = 1'b1;
         end else begin
            blk_valid_i = 1'b0;
         end
         tick();
         if (k >= 1 && k <= 30) begin
            chk("t5_valid", out_valid_o, 1'b1);
            chk("t5_data",  out_data_o,  s5[k-1]);
            chk("t5_last",  out_last_o,  (((k - 1) % 3) == 2) ? 1'b1 : 1'b0);
            chk("t5_ready", blk_ready_o, 1'b1);
         end
         if (k == 31) begin
            chk("t5_idle_valid", out_valid_o, 1'b0);
         end
      end

      // 6: flush after lane 0; block offered during flush is dropped
      set_blk(64'hF0, 64'hF1, 64'hF2);
      blk_valid_i = 1'b1;
      tick();
      blk_valid_i = 1'b0;
      tick();
      chk("t6_f0_data", out_data_o, 64'hF0);
      flush_i = 1'b1;
      set_blk(64'hE0, 64'hE1, 64'hE2);
      blk_valid_i = 1'b1;
      tick();
      flush_i     = 1'b0;
      blk_valid_i = 1'b0;
      chk("t6_fl_valid", out_valid_o, 1'b0);
      chk("t6_fl_occ",   occupancy_o, 2'd0);
      chk("t6_fl_last",  out_last_o,  1'b0);
      chk("t6_fl_data",  out_data_o,  64'hF0);
      chk("t6_fl_ready", blk_ready_o, 1'b1);
      tick();
      chk("t6_drop_valid", out_valid_o, 1'b0);
      chk("t6_drop_occ",   occupancy_o, 2'd0);
      set_blk(64'h81, 64'h82, 64'h83);
      blk_valid_i = 1'b1;
      tick();
      blk_valid_i = 1'b0;
      tick();
      chk("t6_h0_data", out_data_o, 64'h81);
      chk("t6_h0_last", out_last_o, 1'b0);
      tick();
      chk("t6_h1_data", out_data_o, 64'h82);
      tick();
      chk("t6_h2_data", out_data_o, 64'h83);
      chk("t6_h2_last", out_last_o, 1'b1);
      tick();

      // 7: reset in the middle of a block
      set_blk(64'h91, 64'h92, 64'h93);
      blk_valid_i = 1'b1;
      tick();
      blk_valid_i = 1'b0;
      tick();
      chk("t7_s0_data", out_data_o, 64'h91);
      reset_n = 1'b0;
      #1;
      chk("t7_rst_valid", out_valid_o, 1'b0);
      chk("t7_rst_occ",   occupancy_o, 2'd0);
      chk("t7_rst_ready", blk_ready_o, 1'b0);
      tick();
      reset_n = 1'b1;
      tick();
      chk("t7_rel_ready", blk_ready_o, 1'b1);
      chk("t7_rel_valid", out_valid_o, 1'b0);
      tick();
      chk("t7_quiet_valid", out_valid_o, 1'b0);
      chk("t7_quiet_occ",   occupancy_o, 2'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
